lcd_box_overlay: RTL and testbench

//  Multi-rectangle border overlay for the 640x480 LCD/VGA output path. Draws up to NUM_BOX

---
 rtl/lcd_box_overlay.sv | 101 ++++++++++
 tb/tb_lcd_box_overlay.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_box_overlay.sv
// lcd_box_overlay: frame-shadowed multi-rectangle border overlay with blink on an RGB565 pixel stream.
module lcd_box_overlay #(
  parameter int NUM_BOX      = 8,
  parameter int COORD_W      = 10,
  parameter int BORDER       = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         lcd_clk,
  input  logic                         sys_rst,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [COORD_W-1:0]           pixel_xpos,
  input  logic [COORD_W-1:0]           pixel_ypos,
  input  logic [15:0]                  pix_rgb,
  input  logic [NUM_BOX*COORD_W-1:0]   box_left,
  input  logic [NUM_BOX*COORD_W-1:0]   box_right,
  input  logic [NUM_BOX*COORD_W-1:0]   box_up,
  input  logic [NUM_BOX*COORD_W-1:0]   box_down,
  input  logic [NUM_BOX-1:0]           box_en,
  input  logic [NUM_BOX-1:0]           box_blink,
  input  logic [NUM_BOX*16-1:0]        box_color,
  output logic [15:0]                  out_rgb,
  output logic                         out_valid,
  output logic [NUM_BOX-1:0]           out_hit,
  output logic [3:0]                   VGA_R,
  output logic [3:0]                   VGA_G,
  output logic [3:0]                   VGA_B
);
  localparam int W  = COORD_W + $clog2(BORDER + 1) + 1;
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [W-1:0]  B    = W'(BORDER);
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);
  logic [NUM_BOX*COORD_W-1:0] left_sh, right_sh, up_sh, down_sh;
  logic [NUM_BOX-1:0]         en_sh, blink_sh, hit, hit_q;
  logic [NUM_BOX*16-1:0]      color_sh;
  logic [CW-1:0]              cnt;
  logic                       phase, v_q;
  logic [15:0]                col, col_q, rgb_q;
  logic [W-1:0]               x, y;
  assign x = W'(pixel_xpos);
  assign y = W'(pixel_ypos);
  // Edge tests are rearranged into additions so nothing can go negative and wrap.
  for (genvar i = 0; i < NUM_BOX; i++) begin : g_box
    logic [W-1:0] l, r, u, d;
    assign l = W'(left_sh[i*COORD_W +: COORD_W]);
    assign r = W'(right_sh[i*COORD_W +: COORD_W]);
    assign u = W'(up_sh[i*COORD_W +: COORD_W]);
    assign d = W'(down_sh[i*COORD_W +: COORD_W]);
    assign hit[i] = en_sh[i] && l < r && u < d &&
                    x >= l && x <= r && y >= u && y <= d &&
                    (y < u + B || y + B > d || x < l + B || x + B > r) &&
                    !(blink_sh[i] && phase);
  end
  always_comb begin
    col = '0;
    for (int i = NUM_BOX - 1; i >= 0; i--)
      if (hit[i]) col = color_sh[i*16 +: 16];
  end
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      left_sh   <= '0;
      right_sh  <= '0;
      up_sh     <= '0;
      down_sh   <= '0;
      en_sh     <= '0;
      blink_sh  <= '0;
      color_sh  <= '0;
      cnt       <= '0;
      phase     <= 1'b0;
      hit_q     <= '0;
      col_q     <= '0;
      rgb_q     <= '0;
      v_q       <= 1'b0;
      out_rgb   <= '0;
      out_valid <= 1'b0;
      out_hit   <= '0;
    end else begin
      if (frame_start) begin
        left_sh  <= box_left;
        right_sh <= box_right;
        up_sh    <= box_up;
        down_sh  <= box_down;
        en_sh    <= box_en;
        blink_sh <= box_blink;
        color_sh <= box_color;
        cnt      <= cnt == LAST ? '0 : cnt + CW'(1);
        phase    <= phase ^ (cnt == LAST);
      end
      hit_q     <= hit;
      col_q     <= col;
      rgb_q     <= pix_rgb;
      v_q       <= pix_valid;
      out_valid <= v_q;
      out_hit   <= v_q ? hit_q : '0;
      out_rgb   <= !v_q ? '0 : |hit_q ? col_q : rgb_q;
    end
  end
  assign VGA_R = out_rgb[15:12];
  assign VGA_G = out_rgb[10:7];
  assign VGA_B = out_rgb[4:1];
endmodule

// File: tb/tb_lcd_box_overlay.sv
// tb_lcd_box_overlay: directed pixels with a queued scoreboard for two overlay configurations.
module tb_lcd_box_overlay;
  typedef struct {
    int          cyc;
    logic [15:0] rgb;
    logic [7:0]  hit;
  } exp_t;
  logic clk, rst, mon_on;
  int   cyc, compared, fails;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic        a_fs, a_valid;
  logic [9:0]  a_x, a_y;
  logic [15:0] a_pix;
  logic [79:0] a_l, a_r, a_u, a_d;
  logic [7:0]  a_en, a_blink, a_hit;
  logic [127:0] a_col;
  logic [15:0] a_rgb;
  logic        a_ov;
  logic [3:0]  a_vr, a_vg, a_vb;
  logic        b_fs, b_valid;
  logic [9:0]  b_x, b_y;
  logic [15:0] b_pix;
  logic [19:0] b_l, b_r, b_u, b_d;
  logic [1:0]  b_en, b_blink, b_hit;
  logic [31:0] b_col;
  logic [15:0] b_rgb;
  logic        b_ov;
  logic [3:0]  b_vr, b_vg, b_vb;
  lcd_box_overlay #(.NUM_BOX(8), .COORD_W(10), .BORDER(2), .BLINK_FRAMES(2)) dut_a (
    .lcd_clk(clk), .sys_rst(rst), .frame_start(a_fs), .pix_valid(a_valid),
    .pixel_xpos(a_x), .pixel_ypos(a_y), .pix_rgb(a_pix),
    .box_left(a_l), .box_right(a_r), .box_up(a_u), .box_down(a_d),
    .box_en(a_en), .box_blink(a_blink), .box_color(a_col),
    .out_rgb(a_rgb), .out_valid(a_ov), .out_hit(a_hit),
    .VGA_R(a_vr), .VGA_G(a_vg), .VGA_B(a_vb));
  lcd_box_overlay #(.NUM_BOX(2), .COORD_W(10), .BORDER(40), .BLINK_FRAMES(30)) dut_b (
    .lcd_clk(clk), .sys_rst(rst), .frame_start(b_fs), .pix_valid(b_valid),
    .pixel_xpos(b_x), .pixel_ypos(b_y), .pix_rgb(b_pix),
    .box_left(b_l), .box_right(b_r), .box_up(b_u), .box_down(b_d),
    .box_en(b_en), .box_blink(b_blink), .box_color(b_col),
    .out_rgb(b_rgb), .out_valid(b_ov), .out_hit(b_hit),
    .VGA_R(b_vr), .VGA_G(b_vg), .VGA_B(b_vb));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;
  always @(negedge clk) if (mon_on) begin
    compared++;
    if (a_ov) begin
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL a_extra: out_rgb=%h appeared with no expected pixel", a_rgb);
      end else begin
        ea = qa.pop_front();
        if (a_rgb !== ea.rgb || a_hit !== ea.hit || cyc !== ea.cyc + 2 ||
            {a_vr, a_vg, a_vb} !== {a_rgb[15:12], a_rgb[10:7], a_rgb[4:1]}) begin
          fails++;
          $display("FAIL a_pixel: got rgb=%h hit=%b cyc=%0d vga=%h%h%h, want rgb=%h hit=%b cyc=%0d",
                   a_rgb, a_hit, cyc, a_vr, a_vg, a_vb, ea.rgb, ea.hit, ea.cyc + 2);
        end
      end
    end else if (a_rgb !== 16'h0 || a_hit !== 8'h0) begin
      fails++;
      $display("FAIL a_idle: got rgb=%h hit=%b, want 0 while invalid", a_rgb, a_hit);
    end
  end
  always @(negedge clk) if (mon_on) begin
    compared++;
    if (b_ov) begin
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL b_extra: out_rgb=%h appeared with no expected pixel", b_rgb);
      end else begin
        eb = qb.pop_front();
        if (b_rgb !== eb.rgb || {6'b0, b_hit} !== eb.hit || cyc !== eb.cyc + 2) begin
          fails++;
          $display("FAIL b_pixel: got rgb=%h hit=%b cyc=%0d, want rgb=%h hit=%b cyc=%0d",
                   b_rgb, b_hit, cyc, eb.rgb, eb.hit[1:0], eb.cyc + 2);
        end
      end
    end else if (b_rgb !== 16'h0 || b_hit !== 2'b0) begin
      fails++;
      $display("FAIL b_idle: got rgb=%h hit=%b, want 0 while invalid", b_rgb, b_hit);
    end
  end
  task automatic set_a(input int i, input int l, r, u, d, input logic [15:0] c);
    a_l[i*10 +: 10] = 10'(l);
    a_r[i*10 +: 10] = 10'(r);
    a_u[i*10 +: 10] = 10'(u);
    a_d[i*10 +: 10] = 10'(d);
    a_col[i*16 +: 16] = c;
  endtask
  task automatic set_b(input int i, input int l, r, u, d, input logic [15:0] c);
    b_l[i*10 +: 10] = 10'(l);
    b_r[i*10 +: 10] = 10'(r);
    b_u[i*10 +: 10] = 10'(u);
    b_d[i*10 +: 10] = 10'(d);
    b_col[i*16 +: 16] = c;
  endtask
  task automatic pix(input bit s, input int x, y, input logic [15:0] rgb, er,
                     input logic [7:0] eh, input bit fs);
    @(posedge clk); #1;
    a_valid = !s; b_valid = s; a_fs = !s && fs; b_fs = s && fs;
    if (!s) begin
      a_x = 10'(x); a_y = 10'(y); a_pix = rgb;
      qa.push_back('{cyc, er, eh});
    end else begin
      b_x = 10'(x); b_y = 10'(y); b_pix = rgb;
      qb.push_back('{cyc, er, eh});
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_valid = 0; b_valid = 0; a_fs = 0; b_fs = 0;
    end
  endtask
  task automatic fstart(input bit s);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0; a_fs = !s; b_fs = s;
  endtask
  logic [15:0] blink_exp [5];
  initial begin
    mon_on = 0; cyc = 0; compared = 0; fails = 0;
    rst = 1;
    {a_fs, a_valid, a_x, a_y, a_pix, a_l, a_r, a_u, a_d, a_en, a_blink, a_col} = '0;
    {b_fs, b_valid, b_x, b_y, b_pix, b_l, b_r, b_u, b_d, b_en, b_blink, b_col} = '0;
    idle(3);
    compared++;
    if ({a_rgb, a_ov, a_hit, b_rgb, b_ov, b_hit} !== '0) begin
      fails++;
      $display("FAIL reset_state: got a_rgb=%h a_valid=%b a_hit=%b, want all 0", a_rgb, a_ov, a_hit);
    end
    rst = 0;
    mon_on = 1;
    // no frame_start yet: box inputs must have no effect
    set_a(0, 100, 200, 50, 120, 16'hF800);
    a_en = 8'h01;
    pix(0, 100, 50, 16'h1234, 16'h1234, 8'h00, 0);
    pix(0, 150, 80, 16'hABCD, 16'hABCD, 8'h00, 0);
    pix(0, 0, 0, 16'hFFFF, 16'hFFFF, 8'h00, 0);
    idle(2);
    // pixel in the frame_start cycle still sees the old (empty) shadow
    pix(0, 100, 50, 16'h5555, 16'h5555, 8'h00, 1);
    pix(0, 100, 50, 16'h1111, 16'hF800, 8'h01, 0);
    pix(0, 101, 80, 16'h1111, 16'hF800, 8'h01, 0);
    pix(0, 200, 120, 16'h1111, 16'hF800, 8'h01, 0);
    pix(0, 150, 119, 16'h1111, 16'hF800, 8'h01, 0);
    pix(0, 102, 80, 16'h2222, 16'h2222, 8'h00, 0);
    pix(0, 150, 117, 16'h3333, 16'h3333, 8'h00, 0);
    pix(0, 99, 50, 16'h4444, 16'h4444, 8'h00, 0);
    idle(2);
    // overlapping boxes and a degenerate left==right box
    set_a(0, 10, 60, 10, 60, 16'h07E0);
    set_a(1, 50, 100, 50, 100, 16'h001F);
    set_a(2, 300, 300, 10, 20, 16'hFFE0);
    a_en = 8'h07;
    fstart(0);
    pix(0, 60, 50, 16'h0101, 16'h07E0, 8'h03, 0);
    pix(0, 300, 10, 16'h0202, 16'h0202, 8'h00, 0);
    pix(0, 55, 55, 16'h0303, 16'h0303, 8'h00, 0);
    pix(0, 75, 50, 16'h0404, 16'h001F, 8'h02, 0);
    idle(2);
    // mid-frame coordinate change is held off until the next frame_start
    a_l[9:0] = 10'd0;
    pix(0, 0, 30, 16'h0404, 16'h0404, 8'h00, 0);
    idle(3);
    pix(0, 0, 30, 16'h0505, 16'h0505, 8'h00, 1);
    pix(0, 0, 30, 16'h0606, 16'h07E0, 8'h01, 0);
    pix(0, 60, 50, 16'h0707, 16'h07E0, 8'h03, 0);
    pix(0, 61, 50, 16'h0808, 16'h001F, 8'h02, 0);
    #2 rst = 1;
    #1;
    compared++;
    if ({a_rgb, a_ov, a_hit, a_vr, a_vg, a_vb} !== '0) begin
      fails++;
      $display("FAIL async_reset: got rgb=%h valid=%b hit=%b, want all 0", a_rgb, a_ov, a_hit);
    end
    qa.delete();
    a_valid = 0;
    @(posedge clk); #1 rst = 0;
    idle(2);
    pix(0, 60, 50, 16'h0909, 16'h0909, 8'h00, 0);
    pix(0, 0, 30, 16'h0A0A, 16'h0A0A, 8'h00, 0);
    idle(2);
    // blink with a 2-frame half period: shown, hidden, hidden, shown, shown
    set_a(0, 100, 200, 50, 120, 16'hF800);
    a_en = 8'h01;
    a_blink = 8'h01;
    blink_exp = '{16'hF800, 16'h0B00, 16'h0B00, 16'hF800, 16'hF800};
    for (int k = 0; k < 5; k++) begin
      fstart(0);
      pix(0, 100, 50, 16'h0B00, blink_exp[k], blink_exp[k] == 16'hF800 ? 8'h01 : 8'h00, 0);
      idle(2);
    end
    // thick border: boxes fill entirely, no wrap on the far-edge test
    set_b(0, 10, 60, 10, 60, 16'h07E0);
    set_b(1, 50, 100, 50, 100, 16'h001F);
    b_en = 2'b11;
    fstart(1);
    pix(1, 55, 55, 16'h1010, 16'h07E0, 8'h03, 0);
    pix(1, 80, 80, 16'h1111, 16'h001F, 8'h02, 0);
    pix(1, 5, 5, 16'h1212, 16'h1212, 8'h00, 0);
    idle(2);
    set_b(0, 200, 219, 200, 219, 16'h07E0);
    b_en = 2'b01;
    fstart(1);
    pix(1, 210, 210, 16'h1313, 16'h07E0, 8'h01, 0);
    pix(1, 219, 219, 16'h1414, 16'h07E0, 8'h01, 0);
    pix(1, 220, 210, 16'h1515, 16'h1515, 8'h00, 0);
    pix(1, 80, 80, 16'h1616, 16'h1616, 8'h00, 0);
    idle(5);
    compared++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pixels still pending, want 0/0", qa.size(), qb.size());
    end
    mon_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end
endmodule
